// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: mux select codes, source indices and base-priority pick.
package wb_arbiter_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned NumSrc         = 3;

    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_DM  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef enum logic [1:0] {
        SrcPc  = 2'd0,
        SrcDm  = 2'd1,
        SrcAlu = 2'd2
    } src_e;

    // One-hot grant of the highest base-priority request: DM > ALU > PC.
    function automatic logic [NumSrc-1:0] pick_fixed(logic [NumSrc-1:0] req);
        logic [NumSrc-1:0] gnt;
        gnt = '0;
        if (req[SrcDm]) begin
            gnt[SrcDm] = 1'b1;
        end else if (req[SrcAlu]) begin
            gnt[SrcAlu] = 1'b1;
        end else if (req[SrcPc]) begin
            gnt[SrcPc] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back port bundle: source requests, load issue, hazard check and register-bank write.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) ();

    logic              pc_valid;
    logic [REG_AW-1:0] pc_rd;
    logic              pc_ready;
    logic              dm_valid;
    logic [REG_AW-1:0] dm_rd;
    logic              dm_ready;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic              alu_ready;
    logic              dm_issue;
    logic [REG_AW-1:0] dm_issue_rd;
    logic [REG_AW-1:0] chk_rs1;
    logic [REG_AW-1:0] chk_rs2;
    logic              hazard;
    logic [1:0]        S_MXRB;
    logic              rb_we;
    logic [REG_AW-1:0] rb_waddr;

    modport master (
        output pc_valid, pc_rd, dm_valid, dm_rd, alu_valid, alu_rd,
        output dm_issue, dm_issue_rd, chk_rs1, chk_rs2,
        input  pc_ready, dm_ready, alu_ready, hazard, S_MXRB, rb_we, rb_waddr
    );

    modport slave (
        input  pc_valid, pc_rd, dm_valid, dm_rd, alu_valid, alu_rd,
        input  dm_issue, dm_issue_rd, chk_rs1, chk_rs2,
        output pc_ready, dm_ready, alu_ready, hazard, S_MXRB, rb_we, rb_waddr
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Load scoreboard: one pending bit per register, set on load issue, cleared on load write-back.
module wb_scoreboard #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output logic              hit1_o,
    output logic              hit2_o
);

    localparam int unsigned Depth = 1 << REG_AW;

    logic [Depth-1:0] sb_q;
    logic [Depth-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_i) begin
            sb_d[clr_idx_i] = 1'b0;
        end
        // Set applied after clear so a same-cycle issue to that register wins; r0 never tracks.
        if (set_i && (set_idx_i != '0)) begin
            sb_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign hit1_o = sb_q[rs1_i];
    assign hit2_o = sb_q[rs2_i];

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one register-bank write per cycle and flags read-after-load hazards.
// Define WB_ARB_RR_EN for round-robin arbitration instead of fixed priority with aging.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);

    logic [NumSrc-1:0] valid;
    logic [NumSrc-1:0] grant;
    logic [REG_AW-1:0] wr_addr;
    logic              hit1;
    logic              hit2;

    assign valid = {bus.alu_valid, bus.dm_valid, bus.pc_valid};

`ifdef WB_ARB_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Scan starts at the pointer and wraps PC -> DM -> ALU -> PC.
    always_comb begin
        grant = '0;
        case (ptr_q)
            2'd1: begin
                if (valid[SrcDm])       grant[SrcDm]  = 1'b1;
                else if (valid[SrcAlu]) grant[SrcAlu] = 1'b1;
                else if (valid[SrcPc])  grant[SrcPc]  = 1'b1;
            end
            2'd2: begin
                if (valid[SrcAlu])      grant[SrcAlu] = 1'b1;
                else if (valid[SrcPc])  grant[SrcPc]  = 1'b1;
                else if (valid[SrcDm])  grant[SrcDm]  = 1'b1;
            end
            default: begin
                if (valid[SrcPc])       grant[SrcPc]  = 1'b1;
                else if (valid[SrcDm])  grant[SrcDm]  = 1'b1;
                else if (valid[SrcAlu]) grant[SrcAlu] = 1'b1;
            end
        endcase
        if (reset) begin
            grant = '0;
        end

        ptr_d = ptr_q;
        if (grant[SrcPc])  ptr_d = 2'd1;
        if (grant[SrcDm])  ptr_d = 2'd2;
        if (grant[SrcAlu]) ptr_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    localparam int unsigned     CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [CntW-1:0]   cnt_q [NumSrc];
    logic [CntW-1:0]   cnt_d [NumSrc];
    logic [NumSrc-1:0] starved;

    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            starved[i] = valid[i] && (cnt_q[i] == CntMax);
        end
        // Starved requesters pre-empt everyone; base priority still orders them.
        grant = (|starved) ? pick_fixed(starved) : pick_fixed(valid);
        if (reset) begin
            grant = '0;
        end

        for (int i = 0; i < NumSrc; i++) begin
            if (!valid[i] || grant[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CntMax) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumSrc; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        bus.S_MXRB = SEL_PC;
        wr_addr    = '0;
        if (grant[SrcDm]) begin
            bus.S_MXRB = SEL_DM;
            wr_addr    = bus.dm_rd;
        end else if (grant[SrcAlu]) begin
            bus.S_MXRB = SEL_ALU;
            wr_addr    = bus.alu_rd;
        end else if (grant[SrcPc]) begin
            wr_addr    = bus.pc_rd;
        end
    end

    assign bus.pc_ready  = grant[SrcPc];
    assign bus.dm_ready  = grant[SrcDm];
    assign bus.alu_ready = grant[SrcAlu];
    assign bus.rb_waddr  = wr_addr;
    // r0 writes are accepted but suppressed at the bank.
    assign bus.rb_we     = (grant != '0) && (wr_addr != '0);
    assign bus.hazard    = !reset && (hit1 || hit2);

    wb_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_i     (reset),
        .set_i     (bus.dm_issue),
        .set_idx_i (bus.dm_issue_rd),
        .clr_i     (grant[SrcDm]),
        .clr_idx_i (bus.dm_rd),
        .rs1_i     (bus.chk_rs1),
        .rs2_i     (bus.chk_rs2),
        .hit1_o    (hit1),
        .hit2_o    (hit2)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (default fixed-priority build): vector table, directed corner sequences
// and a randomized run checked every cycle against a behavioural reference model.
module tb_wb_arbiter;

    localparam int AW    = 5;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;

    wb_arbiter_if #(.REG_AW(AW)) bus ();

    wb_arbiter #(
        .REG_AW       (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: per-source wait counts (0 = PC, 1 = DM, 2 = ALU), pending-load bits.
    int mcnt [3];
    bit msb  [32];
    int mgnt = -1;

    typedef struct {
        bit         pv;
        int         prd;
        bit         dv;
        int         drd;
        bit         av;
        int         ard;
        logic [2:0] rdy;
        logic [1:0] sel;
        bit         we;
        int         wa;
    } vec_t;

    vec_t       tab [9];
    logic [1:0] starve_sel [6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit pv, int prd, bit dv, int drd, bit av, int ard);
        bus.pc_valid  = pv;
        bus.pc_rd     = AW'(prd);
        bus.dm_valid  = dv;
        bus.dm_rd     = AW'(drd);
        bus.alu_valid = av;
        bus.alu_rd    = AW'(ard);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
        bus.dm_issue = 1'b0;
    endtask

    function automatic logic [11:0] outs();
        return {bus.pc_ready, bus.dm_ready, bus.alu_ready, bus.S_MXRB, bus.rb_we,
                bus.rb_waddr, bus.hazard};
    endfunction

    task automatic model_check(string nm);
        bit         v [3];
        int         r [3];
        int         order [3];
        logic [2:0] e_rdy;
        int         e_wa;
        bit         e_we;
        bit         e_haz;
        order = '{1, 2, 0};
        v     = '{bus.pc_valid, bus.dm_valid, bus.alu_valid};
        r     = '{int'(bus.pc_rd), int'(bus.dm_rd), int'(bus.alu_rd)};
        mgnt  = -1;
        if (!reset) begin
            // Pass 0 considers only sources that have waited LIMIT cycles, pass 1 everyone.
            for (int pass = 0; pass < 2; pass++) begin
                for (int j = 0; j < 3; j++) begin
                    if (mgnt < 0 && v[order[j]] && (pass == 1 || mcnt[order[j]] >= LIMIT)) begin
                        mgnt = order[j];
                    end
                end
            end
        end
        e_rdy = (mgnt == 0) ? 3'b100 : (mgnt == 1) ? 3'b010 : (mgnt == 2) ? 3'b001 : 3'b000;
        e_wa  = (mgnt < 0) ? 0 : r[mgnt];
        e_we  = (mgnt >= 0) && (e_wa != 0);
        e_haz = !reset && (msb[bus.chk_rs1] || msb[bus.chk_rs2]);
        // Select code equals source index (PC 0, DM 1, ALU 2); 0 when idle.
        chk(nm, 32'(outs()),
            32'({e_rdy, 2'((mgnt < 0) ? 0 : mgnt), e_we, 5'(e_wa), e_haz}));
    endtask

    task automatic model_update();
        bit v [3];
        v = '{bus.pc_valid, bus.dm_valid, bus.alu_valid};
        if (reset) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            foreach (msb[i]) msb[i] = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] || mgnt == i) mcnt[i] = 0;
                else if (mcnt[i] < LIMIT) mcnt[i]++;
            end
            if (bus.dm_issue && bus.dm_issue_rd != 0 && msb[bus.dm_issue_rd]) begin
                n_bad++;
                $display("FAIL illegal_issue: rd %0d already pending", bus.dm_issue_rd);
            end
            if (mgnt == 1) msb[bus.dm_rd] = 1'b0;
            if (bus.dm_issue && bus.dm_issue_rd != 0) msb[bus.dm_issue_rd] = 1'b1;
        end
    endtask

    task automatic half(string nm);
        @(negedge clk);
        model_check(nm);
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick(string nm);
        half(nm);
        edge_step();
    endtask

    initial begin
        tab[0] = '{0, 0, 0, 0, 1, 7, 3'b001, 2'b10, 1, 7};
        tab[1] = '{0, 0, 1, 3, 0, 0, 3'b010, 2'b01, 1, 3};
        tab[2] = '{1, 12, 0, 0, 0, 0, 3'b100, 2'b00, 1, 12};
        tab[3] = '{1, 0, 0, 0, 0, 0, 3'b100, 2'b00, 0, 0};
        tab[4] = '{1, 1, 1, 2, 1, 3, 3'b010, 2'b01, 1, 2};
        tab[5] = '{1, 5, 0, 0, 1, 4, 3'b001, 2'b10, 1, 4};
        tab[6] = '{1, 6, 1, 11, 0, 0, 3'b010, 2'b01, 1, 11};
        tab[7] = '{0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0};
        tab[8] = '{0, 0, 1, 0, 0, 0, 3'b010, 2'b01, 0, 0};
        starve_sel = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};

        // Reset with every source requesting: all outputs held at zero.
        reset = 1'b1;
        drive(1, 1, 1, 2, 1, 3);
        bus.dm_issue    = 1'b0;
        bus.dm_issue_rd = '0;
        bus.chk_rs1     = '0;
        bus.chk_rs2     = '0;
        half("reset_model");
        chk("reset_outputs", 32'(outs()), 32'(0));
        edge_step();
        reset = 1'b0;
        idle();
        tick("idle_after_reset");

        for (int i = 0; i < 9; i++) begin
            drive(tab[i].pv, tab[i].prd, tab[i].dv, tab[i].drd, tab[i].av, tab[i].ard);
            half("tab_model");
            chk($sformatf("tab%0d", i),
                32'({bus.pc_ready, bus.dm_ready, bus.alu_ready, bus.S_MXRB, bus.rb_we,
                     bus.rb_waddr}),
                32'({tab[i].rdy, tab[i].sel, tab[i].we, 5'(tab[i].wa)}));
            edge_step();
            idle();
            tick("tab_idle");
        end

        // All three request; DM leaves after its grant; PC must win once its wait hits LIMIT.
        for (int c = 0; c < 6; c++) begin
            drive(1, 3, c == 0, 4, 1, 8);
            half("starve_model");
            chk($sformatf("starve_sel%0d", c), 32'(bus.S_MXRB), 32'(starve_sel[c]));
            edge_step();
        end
        idle();
        tick("starve_idle");

        // Scoreboard: issue to r5, hazard next cycle, cleared the cycle after the DM write.
        bus.dm_issue    = 1'b1;
        bus.dm_issue_rd = 5'd5;
        bus.chk_rs1     = 5'd5;
        half("sb_issue");
        chk("sb_same_cycle_invisible", 32'(bus.hazard), 32'(0));
        edge_step();
        bus.dm_issue = 1'b0;
        half("sb_pending");
        chk("sb_hazard_set", 32'(bus.hazard), 32'(1));
        edge_step();
        drive(0, 0, 1, 5, 0, 0);
        half("sb_writeback");
        chk("sb_hazard_during_wb", 32'(bus.hazard), 32'(1));
        edge_step();
        idle();
        half("sb_cleared");
        chk("sb_hazard_cleared", 32'(bus.hazard), 32'(0));
        edge_step();

        // Same-cycle issue and DM write-back to r9: the set wins.
        drive(0, 0, 1, 9, 0, 0);
        bus.dm_issue    = 1'b1;
        bus.dm_issue_rd = 5'd9;
        bus.chk_rs1     = 5'd0;
        bus.chk_rs2     = 5'd9;
        tick("sb_setclr");
        idle();
        half("sb_set_wins_model");
        chk("sb_set_wins", 32'(bus.hazard), 32'(1));
        edge_step();

        // Reset while ALU waits with a partial count and r9 is pending.
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 1, 1, 1, 6);
            tick("rst_pre");
        end
        reset = 1'b1;
        half("rst_model");
        chk("rst_outputs", 32'(outs()), 32'(0));
        edge_step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 1, 1, 1, 6);
            half("rst_post");
            if (c == 0) chk("rst_sb_cleared", 32'(bus.hazard), 32'(0));
            chk($sformatf("rst_post_alu%0d", c), 32'(bus.alu_ready), 32'(c == 4));
            edge_step();
        end
        idle();
        tick("rst_idle");
        drive(0, 0, 0, 0, 1, 7);
        half("post_rst_model");
        chk("post_rst_grant", 32'({bus.alu_ready, bus.S_MXRB, bus.rb_we, bus.rb_waddr}),
            32'({1'b1, 2'b10, 1'b1, 5'd7}));
        edge_step();
        idle();
        tick("post_rst_idle");

        // Randomized traffic; unaccepted requests are held (occasionally withdrawn).
        for (int n = 0; n < 3000; n++) begin
            int rd;
            reset = ($urandom_range(0, 99) == 0);
            if (!(bus.pc_valid && mgnt != 0 && $urandom_range(0, 7) != 0)) begin
                bus.pc_valid = 1'($urandom_range(0, 1));
                bus.pc_rd    = AW'($urandom_range(0, 7));
            end
            if (!(bus.dm_valid && mgnt != 1 && $urandom_range(0, 7) != 0)) begin
                bus.dm_valid = 1'($urandom_range(0, 1));
                bus.dm_rd    = AW'($urandom_range(0, 7));
            end
            if (!(bus.alu_valid && mgnt != 2 && $urandom_range(0, 7) != 0)) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_rd    = AW'($urandom_range(0, 7));
            end
            rd              = int'($urandom_range(0, 7));
            bus.dm_issue    = ($urandom_range(0, 2) == 0) && !msb[rd];
            bus.dm_issue_rd = AW'(rd);
            bus.chk_rs1     = AW'($urandom_range(0, 7));
            bus.chk_rs2     = AW'($urandom_range(0, 7));
            tick("rand");
        end

        reset = 1'b0;
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back controller for the register-bank write port, sitting between the three result sources (PC link, data memory, ALU) and the write-back select mux.
- Arbitrates one write per cycle and drives the mux select S_MXRB, write enable and destination address.
- Keeps a load scoreboard that flags read-after-load hazards to decode.
- Sources hold data stable while valid && !ready; the controller never buffers data.

Parameters:
- REG_AW, 5, register address width (2**REG_AW registers).
- STARVE_LIMIT, 4, wait cycles after which a waiting source is promoted to top priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_valid  in  1  PC-link write request
- pc_rd  in  REG_AW  PC-link destination
- pc_ready  out  1  PC-link request accepted this cycle
- dm_valid  in  1  load-data write request
- dm_rd  in  REG_AW  load destination
- dm_ready  out  1  load request accepted
- alu_valid  in  1  ALU write request
- alu_rd  in  REG_AW  ALU destination
- alu_ready  out  1  ALU request accepted
- dm_issue  in  1  load issued to data memory this cycle
- dm_issue_rd  in  REG_AW  issued load destination
- chk_rs1  in  REG_AW  decode source register 1
- chk_rs2  in  REG_AW  decode source register 2
- hazard  out  1  a checked source has a pending load
- S_MXRB  out  2  mux select: 00 PC, 01 DM, 10 ALU
- rb_we  out  1  register-bank write enable
- rb_waddr  out  REG_AW  register-bank write address

Behaviour:
- Transfer occurs when X_valid && X_ready in a cycle. The write happens at that clock edge, so latency is 0 cycles (combinational grant).
- At most one ready is high per cycle; ready is never high without the matching valid.
- Grant priority is DM > ALU > PC, except that a starved source is promoted to top priority.
- Each source has a wait counter, saturating at STARVE_LIMIT:
  - Increments while valid && !ready.
  - Clears on grant or when valid is low.
  - A source is starved when its counter == STARVE_LIMIT.
  - If several sources are starved, base priority applies among them.
- S_MXRB encodes the granted source. When nothing is granted, S_MXRB = 00, rb_we = 0 and rb_waddr = 0.
- Writes to register 0: the request is accepted (ready = 1) but rb_we = 0.
- Scoreboard (2**REG_AW bits, registered):
  - dm_issue sets bit[dm_issue_rd] at the next edge.
  - A DM transfer clears bit[dm_rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is never set.
- hazard = sb[chk_rs1] | sb[chk_rs2], combinational from the registered scoreboard. A register index of 0 never hazards. A same-cycle dm_issue is not visible until the next cycle.
- Issuing a load to an rd whose bit is already set is illegal (decode must stall on hazard). Bench asserts this never occurs.
- Reset (synchronous):
  - Scoreboard, wait counters and RR pointer clear.
  - While reset is high: all readies = 0, rb_we = 0, S_MXRB = 00, rb_waddr = 0, hazard = 0.
  - In-flight requests are dropped; sources must re-present them after reset.
- A source may drop valid without a transfer. Its counter clears; no write occurs.

Optional Feature:
- Macro WB_ARB_RR_EN.
- Defined: round-robin arbitration among valid sources.
  - Pointer order PC -> DM -> ALU -> PC.
  - The pointer advances to the source after the granted one.
  - Wait counters and starvation promotion are removed.
- Undefined: fixed priority with aging, as above.

Decomposition:
- Shared package holds:
  - Select constants SEL_PC = 2'b00, SEL_DM = 2'b01, SEL_ALU = 2'b10, shared with the mux.
  - Source index enum.
  - Default REG_AW.
- One natural sub-module: wb_scoreboard (set/clear/lookup with two read ports).

Test Plan:
- Single ALU request alu_rd = 7 -> same cycle alu_ready = 1, S_MXRB = 10, rb_we = 1, rb_waddr = 7.
- DM, ALU and PC all valid for 6 cycles:
  - Cycle 0: DM granted.
  - DM then drops; ALU is granted next.
  - PC is granted no later than the cycle its counter reaches 4, even with ALU re-requesting.
- dm_issue rd = 5, then chk_rs1 = 5 -> hazard = 1 from next cycle. DM transfer to rd 5 -> hazard = 0 the following cycle.
- dm_issue rd = 9 and a DM transfer to rd 9 in the same cycle -> bit 9 stays set.
- pc_valid with pc_rd = 0 -> pc_ready = 1, rb_we = 0.
- Reset asserted while ALU is waiting with a partial count -> outputs zero during reset, counters and scoreboard clear. After release, a fresh request is granted normally.
